// File: rtl/vram_text_writer.sv
`default_nettype none
// ============================================================================
// Module  : vram_text_writer
// Brief   : Character stream to text-mode VRAM writer with clear and scroll.
// Revision: 1.0
// ============================================================================
module vram_text_writer #(
    parameter int         COLS  = 80,
    parameter int         ROWS  = 30,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic        clk_25mhz,
    input  logic        reset,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    output logic [19:0] addr_write,
    output logic [7:0]  vram_write_data,
    output logic        vram_we,
    output logic [19:0] addr_rd,
    input  logic [7:0]  vram_rd_data,
    output logic [4:0]  cursor_row,
    output logic [6:0]  cursor_col,
    output logic        busy
);

    localparam logic [19:0] C_COLS_A        = 20'(COLS);
    localparam logic [19:0] C_LAST_ADDR     = 20'(ROWS * COLS - 1);
    localparam logic [19:0] C_LAST_ROW_BASE = 20'((ROWS - 1) * COLS);
    localparam logic [4:0]  C_LAST_ROW      = 5'(ROWS - 1);
    localparam logic [6:0]  C_LAST_COL      = 7'(COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_WRITE       = 3'd1,
        S_CLEAR       = 3'd2,
        S_SCROLL_COPY = 3'd3,
        S_SCROLL_FILL = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  row_q, row_d;
    logic [6:0]  col_q, col_d;
    logic        we_q, we_d;
    logic [19:0] addr_wr_q, addr_wr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [19:0] addr_rd_q, addr_rd_d;
    logic        rd_active_q, rd_active_d;
    logic        scroll_pend_q, scroll_pend_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic [19:0] w_cur_addr;

    assign w_cur_addr = (20'(row_q) * C_COLS_A) + 20'(col_q);

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        we_d          = 1'b0;
        addr_wr_d     = addr_wr_q;
        wdata_d       = wdata_q;
        addr_rd_d     = addr_rd_q;
        rd_active_d   = rd_active_q;
        scroll_pend_d = scroll_pend_q;

        case (state_q)
            S_IDLE: begin
                if (char_valid) begin
                    if (char_data >= 8'h20 && char_data <= 8'h7E) begin
                        state_d   = S_WRITE;
                        we_d      = 1'b1;
                        addr_wr_d = w_cur_addr;
                        wdata_d   = char_data;
                        if (col_q < C_LAST_COL) begin
                            col_d = col_q + 7'd1;
                        end else begin
                            col_d = 7'd0;
                            if (row_q < C_LAST_ROW) begin
                                row_d = row_q + 5'd1;
                            end else begin
                                scroll_pend_d = 1'b1;
                            end
                        end
                    end else begin
                        case (char_data)
                            8'h0A: begin
                                col_d = 7'd0;
                                if (row_q < C_LAST_ROW) begin
                                    row_d = row_q + 5'd1;
                                end else begin
                                    state_d     = S_SCROLL_COPY;
                                    addr_rd_d   = C_COLS_A;
                                    rd_active_d = 1'b1;
                                end
                            end
                            8'h0D: col_d = 7'd0;
                            8'h08: begin
                                // Stepping back one cell is always address-1, even across a row boundary.
                                if (col_q != 7'd0 || row_q != 5'd0) begin
                                    state_d   = S_WRITE;
                                    we_d      = 1'b1;
                                    addr_wr_d = w_cur_addr - 20'd1;
                                    wdata_d   = BLANK;
                                    if (col_q != 7'd0) begin
                                        col_d = col_q - 7'd1;
                                    end else begin
                                        row_d = row_q - 5'd1;
                                        col_d = C_LAST_COL;
                                    end
                                end
                            end
                            8'h0C: begin
                                state_d   = S_CLEAR;
                                row_d     = 5'd0;
                                col_d     = 7'd0;
                                addr_wr_d = 20'd0;
                                wdata_d   = BLANK;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            S_WRITE: begin
                if (scroll_pend_q) begin
                    state_d       = S_SCROLL_COPY;
                    scroll_pend_d = 1'b0;
                    addr_rd_d     = C_COLS_A;
                    rd_active_d   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                // The entry cycle has no strobe; the first write then lands on address 0.
                wdata_d = BLANK;
                if (!we_q) begin
                    we_d      = 1'b1;
                    addr_wr_d = 20'd0;
                end else if (addr_wr_q < C_LAST_ADDR) begin
                    we_d      = 1'b1;
                    addr_wr_d = addr_wr_q + 20'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SCROLL_COPY: begin
                // Read data for addr_rd is captured at the edge closing its cycle and written one row up.
                if (rd_active_q) begin
                    we_d      = 1'b1;
                    addr_wr_d = addr_rd_q - C_COLS_A;
                    wdata_d   = vram_rd_data;
                    if (addr_rd_q < C_LAST_ADDR) begin
                        addr_rd_d = addr_rd_q + 20'd1;
                    end else begin
                        rd_active_d = 1'b0;
                    end
                end else begin
                    state_d   = S_SCROLL_FILL;
                    we_d      = 1'b1;
                    addr_wr_d = C_LAST_ROW_BASE;
                    wdata_d   = BLANK;
                end
            end
            S_SCROLL_FILL: begin
                if (addr_wr_q < C_LAST_ADDR) begin
                    we_d      = 1'b1;
                    addr_wr_d = addr_wr_q + 20'd1;
                    wdata_d   = BLANK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d inside {S_CLEAR, S_SCROLL_COPY, S_SCROLL_FILL});
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            state_q       <= S_CLEAR;
            row_q         <= 5'd0;
            col_q         <= 7'd0;
            we_q          <= 1'b0;
            addr_wr_q     <= 20'd0;
            wdata_q       <= BLANK;
            addr_rd_q     <= 20'd0;
            rd_active_q   <= 1'b0;
            scroll_pend_q <= 1'b0;
            ready_q       <= 1'b0;
            busy_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            we_q          <= we_d;
            addr_wr_q     <= addr_wr_d;
            wdata_q       <= wdata_d;
            addr_rd_q     <= addr_rd_d;
            rd_active_q   <= rd_active_d;
            scroll_pend_q <= scroll_pend_d;
            ready_q       <= ready_d;
            busy_q        <= busy_d;
        end
    end

    assign char_ready      = ready_q;
    assign busy            = busy_q;
    assign vram_we         = we_q;
    assign addr_write      = addr_wr_q;
    assign vram_write_data = wdata_q;
    assign addr_rd         = addr_rd_q;
    assign cursor_row      = row_q;
    assign cursor_col      = col_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_text_writer.sv
`default_nettype none
// ============================================================================
// Module  : tb_vram_text_writer
// Brief   : Self-checking bench for vram_text_writer against a screen model.
// Revision: 1.0
// ============================================================================
module tb_vram_text_writer;

    localparam int         COLS  = 80;
    localparam int         ROWS  = 30;
    localparam int         CELLS = COLS * ROWS;
    localparam logic [7:0] BLANK = 8'h20;

    logic        clk_25mhz = 1'b0;
    logic        reset;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic [19:0] addr_write;
    logic [7:0]  vram_write_data;
    logic        vram_we;
    logic [19:0] addr_rd;
    logic [7:0]  vram_rd_data;
    logic [4:0]  cursor_row;
    logic [6:0]  cursor_col;
    logic        busy;

    vram_text_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
        .clk_25mhz      (clk_25mhz),
        .reset          (reset),
        .char_valid     (char_valid),
        .char_data      (char_data),
        .char_ready     (char_ready),
        .addr_write     (addr_write),
        .vram_write_data(vram_write_data),
        .vram_we        (vram_we),
        .addr_rd        (addr_rd),
        .vram_rd_data   (vram_rd_data),
        .cursor_row     (cursor_row),
        .cursor_col     (cursor_col),
        .busy           (busy)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    // Physical VRAM: data for addr_rd is available to the rising edge that ends its cycle.
    logic [7:0] mem [CELLS];
    always @(posedge clk_25mhz) begin
        if (vram_we === 1'b1 && addr_write < 20'(CELLS)) mem[addr_write] <= vram_write_data;
    end
    assign vram_rd_data = (addr_rd < 20'(CELLS)) ? mem[addr_rd] : 8'h00;

    typedef struct {
        int         addr;
        logic [7:0] data;
    } wr_t;

    wr_t        expq[$];
    logic [7:0] exp_mem [CELLS];
    int         exp_row, exp_col;
    int         checks = 0;
    int         failures = 0;
    int         last_wr_addr = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_wr(input int a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        expq.push_back(w);
        exp_mem[a] = d;
    endtask

    task automatic model_clear();
        for (int i = 0; i < CELLS; i++) push_wr(i, BLANK);
    endtask

    task automatic model_scroll();
        for (int i = 0; i < CELLS - COLS; i++) push_wr(i, exp_mem[i + COLS]);
        for (int i = CELLS - COLS; i < CELLS; i++) push_wr(i, BLANK);
    endtask

    task automatic model_apply(input logic [7:0] c);
        if (c >= 8'h20 && c <= 8'h7E) begin
            push_wr(exp_row * COLS + exp_col, c);
            if (exp_col < COLS - 1) exp_col++;
            else begin
                exp_col = 0;
                if (exp_row < ROWS - 1) exp_row++;
                else model_scroll();
            end
        end else if (c == 8'h0A) begin
            exp_col = 0;
            if (exp_row < ROWS - 1) exp_row++;
            else model_scroll();
        end else if (c == 8'h0D) begin
            exp_col = 0;
        end else if (c == 8'h08) begin
            if (exp_col > 0) begin
                exp_col--;
                push_wr(exp_row * COLS + exp_col, BLANK);
            end else if (exp_row > 0) begin
                exp_row--;
                exp_col = COLS - 1;
                push_wr(exp_row * COLS + exp_col, BLANK);
            end
        end else if (c == 8'h0C) begin
            exp_row = 0;
            exp_col = 0;
            model_clear();
        end
    endtask

    // Advance to the next falling edge and check every write and the cursor/handshake invariants.
    task automatic tick();
        wr_t e;
        @(negedge clk_25mhz);
        if (reset === 1'b0) begin
            if (vram_we === 1'b1) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write addr=%0d data=%0h required=no_write", addr_write, vram_write_data);
                end else begin
                    e = expq.pop_front();
                    chk("wr_addr", 32'(addr_write), 32'(e.addr));
                    chk("wr_data", 32'(vram_write_data), 32'(e.data));
                    last_wr_addr = int'(addr_write);
                end
            end
            chk("legal_outputs", 32'((char_ready & busy) | (cursor_row > 5'd29) | (cursor_col > 7'd79)), 32'd0);
        end
    endtask

    task automatic check_cursor(input string name);
        chk({name, "_row"}, 32'(cursor_row), 32'(exp_row));
        chk({name, "_col"}, 32'(cursor_col), 32'(exp_col));
        chk({name, "_pending"}, 32'(expq.size()), 32'd0);
    endtask

    function automatic int mem_diff();
        int d = 0;
        for (int i = 0; i < CELLS; i++) if (mem[i] !== exp_mem[i]) d++;
        return d;
    endfunction

    task automatic wait_ready(output int busy_cycles, output logic first_busy_we);
        int n = 0;
        busy_cycles   = 0;
        first_busy_we = 1'b1;
        while (char_ready !== 1'b1 && n < 6000) begin
            if (busy === 1'b1) begin
                if (busy_cycles == 0) first_busy_we = vram_we;
                busy_cycles++;
            end
            tick();
            n++;
        end
        if (char_ready !== 1'b1) chk("ready_timeout", 32'(char_ready), 32'd1);
    endtask

    // Present one character for a single accepting edge; optionally keep char_valid high while busy.
    task automatic send_char(input logic [7:0] c, input logic hold,
                             output int busy_cycles, output logic ready_after, output logic first_busy_we);
        model_apply(c);
        char_valid = 1'b1;
        char_data  = c;
        tick();
        if (hold) char_data = 8'h42;
        else begin
            char_valid = 1'b0;
            char_data  = 8'h00;
        end
        ready_after = char_ready;
        wait_ready(busy_cycles, first_busy_we);
        char_valid = 1'b0;
        char_data  = 8'h00;
    endtask

    int   bc;
    logic ra, fw;

    initial begin
        reset      = 1'b1;
        char_valid = 1'b0;
        char_data  = 8'h00;
        exp_row    = 0;
        exp_col    = 0;
        tick();
        tick();
        chk("rst_row", 32'(cursor_row), 32'd0);
        chk("rst_col", 32'(cursor_col), 32'd0);
        chk("rst_ready", 32'(char_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_we", 32'(vram_we), 32'd0);
        chk("rst_addr_write", 32'(addr_write), 32'd0);
        chk("rst_addr_rd", 32'(addr_rd), 32'd0);
        chk("rst_wdata", 32'(vram_write_data), 32'h20);

        model_clear();
        reset = 1'b0;
        wait_ready(bc, fw);
        check_cursor("clear_done");
        chk("clear_busy_low", 32'(busy), 32'd0);
        chk("clear_last_addr", 32'(last_wr_addr), 32'd2399);
        chk("clear_mem", 32'(mem_diff()), 32'd0);

        send_char(8'h41, 1'b0, bc, ra, fw);
        check_cursor("A");
        chk("A_col_lit", 32'(cursor_col), 32'd1);
        chk("A_mem0", 32'(mem[0]), 32'h41);

        for (int i = 0; i < 81; i++) send_char(8'(8'h21 + i), 1'b0, bc, ra, fw);
        check_cursor("run82");
        chk("run82_row_lit", 32'(cursor_row), 32'd1);
        chk("run82_col_lit", 32'(cursor_col), 32'd2);
        chk("run82_last_addr", 32'(last_wr_addr), 32'd81);

        send_char(8'h0D, 1'b0, bc, ra, fw);
        send_char(8'h08, 1'b0, bc, ra, fw);
        check_cursor("bs_wrap");
        chk("bs_wrap_col_lit", 32'(cursor_col), 32'd79);
        chk("bs_wrap_mem79", 32'(mem[79]), 32'h20);
        chk("bs_wrap_addr", 32'(last_wr_addr), 32'd79);

        send_char(8'h0D, 1'b0, bc, ra, fw);
        last_wr_addr = -1;
        send_char(8'h08, 1'b0, bc, ra, fw);
        for (int i = 0; i < 3; i++) tick();
        check_cursor("bs_origin");
        chk("bs_origin_nowrite", 32'(last_wr_addr), 32'hFFFF_FFFF);

        for (int i = 0; i < 3; i++) send_char(8'h0A, 1'b0, bc, ra, fw);
        for (int i = 0; i < 5; i++) send_char(8'h61 + 8'(i), 1'b0, bc, ra, fw);
        send_char(8'h07, 1'b0, bc, ra, fw);
        check_cursor("bel");
        chk("bel_row_lit", 32'(cursor_row), 32'd3);
        chk("bel_col_lit", 32'(cursor_col), 32'd5);
        chk("bel_ready_kept", 32'(ra), 32'd1);

        for (int i = 0; i < 26; i++) send_char(8'h0A, 1'b0, bc, ra, fw);
        for (int i = 0; i < 79; i++) send_char(8'h30 + 8'(i % 10), 1'b0, bc, ra, fw);
        check_cursor("pre_scroll");
        chk("pre_scroll_col_lit", 32'(cursor_col), 32'd79);

        send_char(8'h5A, 1'b1, bc, ra, fw);
        check_cursor("scroll");
        chk("scroll_busy_cycles", 32'(bc), 32'd2401);
        chk("scroll_first_we", 32'(fw), 32'd0);
        chk("scroll_row_lit", 32'(cursor_row), 32'd29);
        chk("scroll_col_lit", 32'(cursor_col), 32'd0);
        chk("scroll_mem0", 32'(mem[0]), 32'h70);
        chk("scroll_mem1", 32'(mem[1]), 32'h71);
        chk("scroll_Z", 32'(mem[2319]), 32'h5A);
        chk("scroll_mem2399", 32'(mem[2399]), 32'h20);
        chk("scroll_mem", 32'(mem_diff()), 32'd0);

        send_char(8'h51, 1'b0, bc, ra, fw);
        send_char(8'h0C, 1'b0, bc, ra, fw);
        check_cursor("ff");
        chk("ff_row_lit", 32'(cursor_row), 32'd0);
        chk("ff_mem", 32'(mem_diff()), 32'd0);
        chk("ff_last_addr", 32'(last_wr_addr), 32'd2399);

        for (int i = 0; i < 29; i++) send_char(8'h0A, 1'b0, bc, ra, fw);
        model_apply(8'h0A);
        char_valid = 1'b1;
        char_data  = 8'h0A;
        tick();
        char_valid = 1'b0;
        char_data  = 8'h00;
        bc = (busy === 1'b1) ? 1 : 0;
        for (int g = 0; g < 3000 && bc < 1000; g++) begin
            tick();
            if (busy === 1'b1) bc++;
        end
        chk("midscroll_busy", 32'(bc), 32'd1000);
        reset = 1'b1;
        expq.delete();
        tick();
        chk("midscroll_rst_we", 32'(vram_we), 32'd0);
        chk("midscroll_rst_addr", 32'(addr_write), 32'd0);
        chk("midscroll_rst_rd", 32'(addr_rd), 32'd0);
        chk("midscroll_rst_row", 32'(cursor_row), 32'd0);
        tick();
        chk("midscroll_rst_we2", 32'(vram_we), 32'd0);
        exp_row = 0;
        exp_col = 0;
        model_clear();
        reset = 1'b0;
        wait_ready(bc, fw);
        check_cursor("reclear");
        chk("reclear_mem", 32'(mem_diff()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
